sdpram_stream_rd: RTL
=====================

SDPRAM_STREAM_RD -- requirements
Module: sdpram_stream_rd

Interface
REQ-001 The block SHALL take parameter DEPTH, default 1000, meaning the word count of the attached sdpram.
REQ-002 The block SHALL take parameter WIDTH, default 17, meaning the data width in bits.
REQ-003 The block SHALL take parameter RD_LAT, default 1, meaning the sdpram read latency in ren-enabled cycles (>=1, else $fatal); AW = $clog2(DEPTH).
REQ-004 clk  in  1  sole clock, all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  command handshake; a transfer occurs when both are high.
REQ-007 cmd_base  in  AW  first read address; cmd_len  in  AW+1  word count, 0..DEPTH.
REQ-008 raddr  out  AW / ren  out  1  drive the sdpram read port; ren is also the sdpram pipeline advance enable.
REQ-009 rdata  in  WIDTH  sdpram read data.
REQ-010 out_valid  out  1 / out_ready  in  1  output stream handshake; out_data  out  WIDTH; out_last  out  1, high on the final word of a command.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE and DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-012 On an IDLE handshake: len=0 -> stay IDLE with no output; len>0 -> load addr=cmd_base and remaining=len, then go to ISSUE.
REQ-013 The output buffer SHALL be a FIFO of RD_LAT+2 entries; ren SHALL be high iff (in-flight tags + FIFO occupancy) < RD_LAT+2.
REQ-014 A read SHALL issue in an ISSUE cycle with ren=1: raddr=addr, a tag enters the stage-0 tag pipe, addr increments, remaining decrements; ISSUE -> DRAIN when remaining reaches 0.
REQ-015 The tag pipe SHALL be RD_LAT stages and SHALL shift only on ren=1, matching the sdpram; a ren=1 cycle outside ISSUE shifts in a 0 tag.
REQ-016 In the cycle after a ren=1 edge that moves a 1-tag into the last stage, rdata SHALL be pushed into the FIFO exactly once, together with a last flag set for the final word of the command.
REQ-017 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL come from the FIFO head; a pop occurs on out_valid&&out_ready; simultaneous push and pop SHALL be legal.
REQ-018 The FIFO SHALL never overflow; out_ready held low SHALL stall issue via ren without losing or duplicating any word.
REQ-019 DRAIN -> IDLE SHALL occur in the cycle the word with out_last is popped; the next command SHALL be accepted no earlier than the following cycle.
REQ-020 Back-to-back throughput SHALL be one word per cycle when out_ready is held high.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously force: state=IDLE, cmd_ready=1 after release, ren=0, raddr=0, out_valid=0, out_last=0, out_data=0, all tags=0, FIFO empty, counters=0.
REQ-022 A reset mid-command SHALL discard all in-flight and buffered words; stale rdata after reset release SHALL never be pushed into the FIFO.

Configuration
REQ-023 With SDPRAM_STREAM_RD_WRAP_EN defined, addr SHALL wrap from DEPTH-1 to 0 and the full cmd_len SHALL be read.
REQ-024 Without SDPRAM_STREAM_RD_WRAP_EN, the effective length SHALL be min(cmd_len, DEPTH-cmd_base), computed at acceptance; out_last SHALL mark the word at DEPTH-1 when truncation applies.

Verification
REQ-025 DEPTH=16, RD_LAT=1, mem[i]=i, base=3, len=4, out_ready=1 -> out_data 3,4,5,6 on consecutive cycles, out_last only on 6, then cmd_ready=1.
REQ-026 RD_LAT=3, base=0, len=10, out_ready toggling 1/0 -> all words 0..9 delivered in order exactly once, FIFO occupancy never exceeds 5.
REQ-027 len=0 -> no out_valid, cmd_ready high again the next cycle.
REQ-028 DEPTH=16, base=14, len=4 -> with WRAP_EN: 14,15,0,1 with last on 1; without it: 14,15 with last on 15.
REQ-029 rst_n pulsed low while a len=8 command is mid-stream -> out_valid=0 immediately; after release, a new command base=0, len=2 yields only 0,1.

Source files
------------

// File: rtl/sdpram_stream_rd.sv
// Streams cmd_len words from a simple dual-port RAM read port onto a valid/ready output.
// Define SDPRAM_STREAM_RD_WRAP_EN to wrap addresses at DEPTH-1 instead of truncating the command.
`timescale 1ns/1ps

module sdpram_stream_rd #(
    parameter  int DEPTH  = 1000,
    parameter  int WIDTH  = 17,
    parameter  int RD_LAT = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_base,
    input  logic [AW:0]      cmd_len,
    output logic [AW-1:0]    raddr,
    output logic             ren,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int FD = RD_LAT + 2;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FD_L      = CW'(FD);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FD - 1);

    if (RD_LAT < 1) begin : g_bad_lat
        $fatal(1, "sdpram_stream_rd: RD_LAT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic [AW-1:0]       addr;
    logic [AW:0]         remaining;
    logic [AW:0]         eff_len;
    logic [RD_LAT-1:0]   tag_v, tag_l;
    logic [RD_LAT-1:0]   tag_v_shift, tag_l_shift;
    logic                ren_q;
    logic [CW-1:0]       used;
    logic [CW-1:0]       fifo_cnt;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [WIDTH-1:0]    fifo_data [FD];
    logic [FD-1:0]       fifo_last;
    logic                accept, issue, issue_last, push, pop;

    always_comb begin
        eff_len = cmd_len;
`ifndef SDPRAM_STREAM_RD_WRAP_EN
        if ({1'b0, cmd_base} >= (AW+1)'(DEPTH))
            eff_len = '0;
        else if (cmd_len > (AW+1)'(DEPTH) - {1'b0, cmd_base})
            eff_len = (AW+1)'(DEPTH) - {1'b0, cmd_base};
`endif
    end

    // used counts words issued but not yet popped (in flight + buffered),
    // so a free credit guarantees a FIFO slot for every outstanding read.
    assign ren        = rst_n && (used < FD_L);
    assign issue      = ren && (state == ISSUE);
    assign issue_last = issue && (remaining == (AW+1)'(1));
    assign accept     = cmd_valid && cmd_ready;
    // ren_q marks a fresh arrival: a tag parked in the last stage is pushed once only.
    assign push       = tag_v[RD_LAT-1] && ren_q;
    assign out_valid  = (fifo_cnt != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last   = out_valid && fifo_last[rd_ptr];
    assign raddr      = addr;

    if (RD_LAT > 1) begin : g_shift
        assign tag_v_shift = {tag_v[RD_LAT-2:0], issue};
        assign tag_l_shift = {tag_l[RD_LAT-2:0], issue_last};
    end else begin : g_shift1
        assign tag_v_shift = issue;
        assign tag_l_shift = issue_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && eff_len != '0) begin
                        addr      <= cmd_base;
                        remaining <= eff_len;
                        state     <= ISSUE;
                        cmd_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        if (remaining == (AW+1)'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v    <= '0;
            tag_l    <= '0;
            ren_q    <= 1'b0;
            used     <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            ren_q <= ren;
            if (ren) begin
                tag_v <= tag_v_shift;
                tag_l <= tag_l_shift;
            end
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
            case ({issue, pop})
                2'b10:   used <= used + CW'(1);
                2'b01:   used <= used - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rdata;
            fifo_last[wr_ptr] <= tag_l[RD_LAT-1];
        end
    end

endmodule
